uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Buffers received bytes downstream of the UART receive controller, with sticky error status. It drains the receiver's single-byte holding register into a first-word-fall-through FIFO using the receiver's `Empty`/`Unload_data` handshake. It latches receiver errors and FIFO overflow into sticky flags, and presents a pop interface to the AXI-lite register front end.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `RX_THRESHOLD`, 8: fill level that raises `Irq`; range 1..DEPTH.
- `Clk`  in  1  system clock; all logic on rising edge.
- `Reset`  in  1  reset, asynchronous and active-high.
- `RX_data`  in  8  byte from the receiver holding register.
- `RX_empty`  in  1  receiver `Empty`; 0 means a byte is waiting.
- `RX_overrun`  in  1  receiver `Overrun`.
- `RX_frame_error`  in  1  receiver `Frame_error`.
- `Unload_data`  out  1  one-cycle pulse that tells the receiver the byte was taken.
- `Rd_en`  in  1  pop request from the register front end.
- `Rd_data`  out  8  head-of-FIFO byte (FWFT).
- `Rd_valid`  out  1  FIFO non-empty.
- `Full`  out  1  count == DEPTH.
- `Count`  out  $clog2(DEPTH)+1  current fill level.
- `Flush`  in  1  synchronous clear of FIFO contents.
- `Clear_status`  in  1  clears all sticky flags.
- `Overflow_sticky`  out  1  a byte was dropped because the FIFO was full.
- `Rx_overrun_sticky`  out  1  the receiver reported overrun.
- `Frame_error_sticky`  out  1  the receiver reported a framing error.
- `Irq`  out  1  `(Count >= RX_THRESHOLD) | any sticky`.

## Operation
- **Capture FSM** has two states, S_CAP_IDLE and S_CAP_ACK.
  - **S_CAP_IDLE**, when `RX_empty == 0`:
    - Push `RX_data` if a slot is free. A slot is free if `!Full`, or if `Full && Rd_en` in the same cycle.
    - Otherwise drop the byte and set `Overflow_sticky`.
    - In either case, set `Unload_data <= 1` and go to S_CAP_ACK.
  - **S_CAP_ACK**: `Unload_data` is high for exactly this cycle. At its end, set `Unload_data <= 0` and go to S_CAP_IDLE unconditionally.
  - The receiver registers `Empty <= 1` on that same edge, so in S_CAP_IDLE one cycle later `RX_empty` is 1. The only exception is a new byte whose stop bit completes on that edge; that byte is genuine and is captured normally.
  - The FSM never captures twice from one holding-register load.
- **FIFO**
  - Memory is `DEPTH` x 8, not reset.
  - `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `Count` is held as an explicit register.
  - Push and pop in the same cycle: both occur and `Count` is unchanged.
  - Pop when empty (`Rd_en && !Rd_valid`): ignored; pointers unchanged.
  - `Rd_data = mem[rd_ptr]` when `Rd_valid`, else 8'h00.
- **Flush** zeroes both pointers and `Count` on the next edge.
  - It overrides any push or pop in the same cycle; a byte captured that cycle is dropped silently, without setting `Overflow_sticky`.
  - The capture FSM and sticky flags are unaffected.
- **Sticky flags**
  - `Rx_overrun_sticky` sets on any cycle with `RX_overrun == 1`.
  - `Frame_error_sticky` sets on any cycle with `RX_frame_error == 1`.
  - `Clear_status` clears all three flags. If a set condition occurs in the same cycle, set wins.
- `Irq` and `Full` are combinational from registered state. They have no combinational path from any input.

## Timing
- **Reset values**: `Unload_data` 0, `Rd_valid` 0, `Full` 0, `Count` 0, `Rd_data` 8'h00, all sticky flags 0, `Irq` 0, FSM in S_CAP_IDLE.
- **Reset mid-handshake**: any pending `Unload_data` is deasserted immediately and FIFO contents are discarded.
- **Latency**:
  - `RX_empty` falls in cycle n; the byte is in the FIFO and `Unload_data` is high in cycle n+1.
  - `Rd_valid` rises in cycle n+1 if the FIFO was empty.
- **Pop**: with `Rd_en && Rd_valid` in cycle n, the next byte appears on `Rd_data` in cycle n+1.
- **Throughput**: at most one capture per 2 cycles, far above any UART rate.

## Test plan
- **Single byte**: hold `RX_empty=0`, `RX_data=8'hA5` until `Unload_data` is seen.
  - `Unload_data` is high for exactly 1 cycle.
  - One cycle later: `Rd_valid=1`, `Rd_data=8'hA5`, `Count=1`.
  - After one `Rd_en`: `Rd_valid=0`, `Rd_data=8'h00`.
- **Fill and wrap**: push 16 bytes 8'h00..8'h0F.
  - `Full=1`, `Count=16`, `Irq=1` once `Count` reaches 8.
  - Pop all 16: data comes out in order.
  - Push 3 more: pointers wrap and the data is correct.
- **Overflow**: with the FIFO full, present 8'hEE.
  - `Unload_data` still pulses; `Overflow_sticky=1`; contents unchanged.
  - Repeat with `Rd_en` in the capture cycle: 8'hEE is accepted, `Count` stays 16, no overflow.
- **Errors**: pulse `RX_frame_error` for 1 cycle.
  - `Frame_error_sticky=1` and `Irq=1`.
  - Assert `Clear_status` alone: flag clears.
  - Assert `Clear_status` in the same cycle as `RX_overrun`: `Rx_overrun_sticky` stays 1.
- **Flush**: with `Count=5`, assert `Flush` in the same cycle as a capture.
  - Next cycle: `Count=0`, `Rd_valid=0`, no overflow flag.
  - `Unload_data` still pulses once.
- **Async reset**: assert `Reset` during S_CAP_ACK.
  - `Unload_data` drops without waiting for a clock edge.
  - All outputs take their reset values.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: drains the UART receive holding register into a FWFT FIFO
// and keeps sticky receiver/overflow error status for the register front end.
module uart_rx_fifo #(
    parameter int DEPTH        = 16,
    parameter int RX_THRESHOLD = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [7:0]               RX_data,
    input  logic                     RX_empty,
    input  logic                     RX_overrun,
    input  logic                     RX_frame_error,
    output logic                     Unload_data,
    input  logic                     Rd_en,
    output logic [7:0]               Rd_data,
    output logic                     Rd_valid,
    output logic                     Full,
    output logic [$clog2(DEPTH):0]   Count,
    input  logic                     Flush,
    input  logic                     Clear_status,
    output logic                     Overflow_sticky,
    output logic                     Rx_overrun_sticky,
    output logic                     Frame_error_sticky,
    output logic                     Irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        S_CAP_IDLE = 1'b0,
        S_CAP_ACK  = 1'b1
    } cap_state_t;

    cap_state_t      r_state;
    cap_state_t      w_state_nxt;
    logic            w_cap;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_ovf;
    logic            r_ovr;
    logic            r_ferr;

    logic            w_full;
    logic            w_valid;
    logic            w_slot_free;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;

    // Capture FSM: one capture per holding-register load, then one ack cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_CAP_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        unique case (r_state)
            S_CAP_IDLE: begin
                if (!RX_empty) begin
                    w_cap       = 1'b1;
                    w_state_nxt = S_CAP_ACK;
                end
            end
            S_CAP_ACK: begin
                w_state_nxt = S_CAP_IDLE;
            end
            default: begin
                w_state_nxt = S_CAP_IDLE;
            end
        endcase
    end

    // The ack cycle is exactly the Unload_data pulse; reset drops it at once.
    assign Unload_data = (r_state == S_CAP_ACK);

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_valid     = (r_count != '0);
    assign w_slot_free = !w_full || Rd_en;
    assign w_push      = w_cap && w_slot_free && !Flush;
    assign w_pop       = Rd_en && w_valid && !Flush;
    assign w_drop      = w_cap && !w_slot_free && !Flush;

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= RX_data;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (Flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Set has priority over Clear_status so no event is lost.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ovf  <= 1'b0;
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (Clear_status) begin
                r_ovf <= 1'b0;
            end
            if (RX_overrun) begin
                r_ovr <= 1'b1;
            end else if (Clear_status) begin
                r_ovr <= 1'b0;
            end
            if (RX_frame_error) begin
                r_ferr <= 1'b1;
            end else if (Clear_status) begin
                r_ferr <= 1'b0;
            end
        end
    end

    assign Rd_valid           = w_valid;
    assign Rd_data            = w_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign Full               = w_full;
    assign Count              = r_count;
    assign Overflow_sticky    = r_ovf;
    assign Rx_overrun_sticky  = r_ovr;
    assign Frame_error_sticky = r_ferr;
    assign Irq                = (r_count >= CW'(RX_THRESHOLD))
                              | r_ovf | r_ovr | r_ferr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: capture handshake, FIFO
// fill/wrap, overflow, sticky errors, flush and asynchronous reset.
module tb_uart_rx_fifo;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] RX_data;
    logic       RX_empty;
    logic       RX_overrun;
    logic       RX_frame_error;
    logic       Unload_data;
    logic       Rd_en;
    logic [7:0] Rd_data;
    logic       Rd_valid;
    logic       Full;
    logic [4:0] Count;
    logic       Flush;
    logic       Clear_status;
    logic       Overflow_sticky;
    logic       Rx_overrun_sticky;
    logic       Frame_error_sticky;
    logic       Irq;

    int tests  = 0;
    int failed = 0;

    uart_rx_fifo #(.DEPTH(16), .RX_THRESHOLD(8)) dut (
        .Clk                (Clk),
        .Reset              (Reset),
        .RX_data            (RX_data),
        .RX_empty           (RX_empty),
        .RX_overrun         (RX_overrun),
        .RX_frame_error     (RX_frame_error),
        .Unload_data        (Unload_data),
        .Rd_en              (Rd_en),
        .Rd_data            (Rd_data),
        .Rd_valid           (Rd_valid),
        .Full               (Full),
        .Count              (Count),
        .Flush              (Flush),
        .Clear_status       (Clear_status),
        .Overflow_sticky    (Overflow_sticky),
        .Rx_overrun_sticky  (Rx_overrun_sticky),
        .Frame_error_sticky (Frame_error_sticky),
        .Irq                (Irq)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Receiver model: present a byte, release it after the ack pulse.
    task automatic capture(input logic [7:0] d, input logic rd);
        RX_data  = d;
        RX_empty = 1'b0;
        Rd_en    = rd;
        tick();
        Rd_en    = 1'b0;
        chk("cap_unload_hi", Unload_data, 1);
        RX_empty = 1'b1;
        tick();
        chk("cap_unload_lo", Unload_data, 0);
    endtask

    task automatic pop();
        Rd_en = 1'b1;
        tick();
        Rd_en = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        RX_data = 8'h00;
        RX_empty = 1'b1;
        RX_overrun = 1'b0;
        RX_frame_error = 1'b0;
        Rd_en = 1'b0;
        Flush = 1'b0;
        Clear_status = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        tick();

        chk("rst_unload", Unload_data, 0);
        chk("rst_valid", Rd_valid, 0);
        chk("rst_full", Full, 0);
        chk("rst_count", Count, 0);
        chk("rst_data", Rd_data, 8'h00);
        chk("rst_sticky", {Overflow_sticky, Rx_overrun_sticky,
                           Frame_error_sticky}, 0);
        chk("rst_irq", Irq, 0);

        // single byte
        RX_data  = 8'hA5;
        RX_empty = 1'b0;
        tick();
        chk("sb_unload", Unload_data, 1);
        chk("sb_valid", Rd_valid, 1);
        chk("sb_data", Rd_data, 8'hA5);
        chk("sb_count", Count, 1);
        RX_empty = 1'b1;
        tick();
        chk("sb_unload_1cyc", Unload_data, 0);
        chk("sb_count_once", Count, 1);
        pop();
        chk("sb_pop_valid", Rd_valid, 0);
        chk("sb_pop_data", Rd_data, 8'h00);
        chk("sb_pop_count", Count, 0);

        // fill
        for (int i = 0; i < 16; i++) begin
            capture(8'(i), 1'b0);
            chk("fill_count", Count, i + 1);
            chk("fill_irq", Irq, (i + 1 >= 8) ? 1 : 0);
        end
        chk("fill_full", Full, 1);
        chk("fill_head", Rd_data, 8'h00);

        // overflow
        capture(8'hEE, 1'b0);
        chk("ovf_sticky", Overflow_sticky, 1);
        chk("ovf_count", Count, 16);
        chk("ovf_head", Rd_data, 8'h00);
        Clear_status = 1'b1;
        tick();
        Clear_status = 1'b0;
        chk("ovf_clear", Overflow_sticky, 0);
        capture(8'hEE, 1'b1);
        chk("ovf_rd_count", Count, 16);
        chk("ovf_rd_sticky", Overflow_sticky, 0);
        chk("ovf_rd_head", Rd_data, 8'h01);

        // drain: 01..0F then EE
        for (int i = 1; i < 16; i++) begin
            chk("drain_data", Rd_data, i);
            pop();
        end
        chk("drain_last", Rd_data, 8'hEE);
        pop();
        chk("drain_count", Count, 0);
        chk("drain_valid", Rd_valid, 0);

        // wrap
        capture(8'h30, 1'b0);
        capture(8'h31, 1'b0);
        capture(8'h32, 1'b0);
        chk("wrap_count", Count, 3);
        for (int i = 0; i < 3; i++) begin
            chk("wrap_data", Rd_data, 8'h30 + i);
            pop();
        end
        chk("wrap_empty", Rd_valid, 0);

        // errors
        RX_frame_error = 1'b1;
        tick();
        RX_frame_error = 1'b0;
        chk("ferr_sticky", Frame_error_sticky, 1);
        chk("ferr_irq", Irq, 1);
        Clear_status = 1'b1;
        tick();
        Clear_status = 1'b0;
        chk("ferr_clear", Frame_error_sticky, 0);
        chk("ferr_irq_clr", Irq, 0);
        Clear_status = 1'b1;
        RX_overrun = 1'b1;
        tick();
        Clear_status = 1'b0;
        RX_overrun = 1'b0;
        chk("ovr_set_wins", Rx_overrun_sticky, 1);
        Clear_status = 1'b1;
        tick();
        Clear_status = 1'b0;
        chk("ovr_clear", Rx_overrun_sticky, 0);

        // flush concurrent with a capture
        for (int i = 0; i < 5; i++) capture(8'h50 + 8'(i), 1'b0);
        chk("fl_pre_count", Count, 5);
        RX_data  = 8'h77;
        RX_empty = 1'b0;
        Flush    = 1'b1;
        tick();
        Flush    = 1'b0;
        chk("fl_count", Count, 0);
        chk("fl_valid", Rd_valid, 0);
        chk("fl_ovf", Overflow_sticky, 0);
        chk("fl_unload", Unload_data, 1);
        RX_empty = 1'b1;
        tick();
        chk("fl_unload_lo", Unload_data, 0);
        chk("fl_count2", Count, 0);

        // async reset in the ack cycle
        RX_frame_error = 1'b1;
        tick();
        RX_frame_error = 1'b0;
        RX_data  = 8'h5A;
        RX_empty = 1'b0;
        tick();
        chk("ar_unload_pre", Unload_data, 1);
        chk("ar_count_pre", Count, 1);
        #2;
        Reset = 1'b1;
        #1;
        chk("ar_unload", Unload_data, 0);
        chk("ar_count", Count, 0);
        chk("ar_valid", Rd_valid, 0);
        chk("ar_data", Rd_data, 8'h00);
        chk("ar_full", Full, 0);
        chk("ar_ferr", Frame_error_sticky, 0);
        chk("ar_irq", Irq, 0);
        RX_empty = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        chk("ar_post_unload", Unload_data, 0);
        chk("ar_post_count", Count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
